// File: rtl/mcl51_capture_pkg.sv
// Shared definitions for the MCL51 input-capture peripheral: FSM states,
// register addresses, status bit positions and the counter width.
package mcl51_capture_pkg;

  localparam int CNT_W = 24;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  // Register map
  localparam logic [3:0] ADDR_PERIOD_HI  = 4'h0;
  localparam logic [3:0] ADDR_PERIOD_MID = 4'h1;
  localparam logic [3:0] ADDR_PERIOD_LO  = 4'h2;
  localparam logic [3:0] ADDR_HIGH_HI    = 4'h3;
  localparam logic [3:0] ADDR_HIGH_MID   = 4'h4;
  localparam logic [3:0] ADDR_HIGH_LO    = 4'h5;
  localparam logic [3:0] ADDR_STATUS     = 4'h6;
  localparam logic [3:0] ADDR_CTRL       = 4'h7;

  // Status byte bit positions
  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  // Control register: bit 0 selects arm (1) or abort (0)
  localparam int CTRL_ARM_BIT = 0;

  // Assemble the status byte from its flags; unused bits read as zero.
  function automatic logic [7:0] status_byte(input logic done,
                                             input logic busy,
                                             input logic ovf);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_DONE_BIT] = done;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_OVF_BIT]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous pin into CORE_CLK and reports single-cycle
// rise/fall pulses plus the synchronized level. SYNC_STAGES must be >= 2.
// Edge pulses appear SYNC_STAGES cycles after the pin changes and are
// consumed by the user on the following edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CORE_CLK,
  input  logic RST_n,
  input  logic async_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer shift chain followed by one history flop for edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would collapse the chain.
  always_ff @(posedge CORE_CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/capture_timer.sv
// Single-channel 24-bit input-capture peripheral on the MCL51 strobe bus.
// Measures period (rise to rise) and high time (rise to fall) of CAPTURE_IN
// in CORE_CLK cycles. OVF_LIMIT is the counter value at which a measurement
// gives up; it defaults to the full 24-bit range and only a shortened build
// lowers it.
module capture_timer
  import mcl51_capture_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [7:0]       DEVICE_ID   = 8'h5B,
  parameter logic [CNT_W-1:0] OVF_LIMIT   = CNT_MAX
) (
  input  logic       CORE_CLK,
  input  logic       RST_n,
  input  logic [3:0] ADDRESS,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  input  logic       STROBE_WR,
  input  logic       CAPTURE_IN,
  output logic       CAPTURE_DONE
);

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] counter_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             done_q;
  logic             ovf_q;
  logic             fall_seen_q;

  logic             rise, fall;
  logic             sync_level_unused;
  logic [6:0]       data_in_unused;

  logic             ctrl_wr, arm_wr, abort_wr;
  logic             busy;
  logic             at_limit;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CORE_CLK (CORE_CLK),
    .RST_n    (RST_n),
    .async_in (CAPTURE_IN),
    .rise     (rise),
    .fall     (fall),
    .level    (sync_level_unused)
  );

  // Only bit 0 of the control byte carries meaning.
  assign data_in_unused = DATA_IN[7:1];

  assign ctrl_wr  = STROBE_WR && (ADDRESS == ADDR_CTRL);
  assign arm_wr   = ctrl_wr &&  DATA_IN[CTRL_ARM_BIT];
  assign abort_wr = ctrl_wr && !DATA_IN[CTRL_ARM_BIT];

  assign busy     = (state_q == ARM) || (state_q == MEASURE);
  assign at_limit = (counter_q == OVF_LIMIT);

  // FSM state register.
  always_ff @(posedge CORE_CLK or negedge RST_n) begin
    if (!RST_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a control write overrides any edge or terminal event.
  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (arm_wr) begin
      state_d = ARM;
    end else if (abort_wr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ARM:     if (rise) state_d = MEASURE;
        MEASURE: if (rise || at_limit) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Measurement datapath: counter, captured results and status flags.
  always_ff @(posedge CORE_CLK or negedge RST_n) begin
    if (!RST_n) begin
      counter_q   <= '0;
      period_q    <= '0;
      high_q      <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      fall_seen_q <= 1'b0;
    end else if (arm_wr) begin
      // Old results stay readable until the new capture overwrites them.
      counter_q   <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      fall_seen_q <= 1'b0;
    end else if (abort_wr) begin
      counter_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          counter_q <= '0;
        end
        ARM: begin
          if (rise) begin
            // The rise cycle itself is the first counted cycle.
            counter_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
            fall_seen_q <= 1'b0;
          end
        end
        MEASURE: begin
          if (fall && !fall_seen_q) begin
            high_q      <= counter_q;
            fall_seen_q <= 1'b1;
          end
          if (rise) begin
            period_q <= counter_q;
            done_q   <= 1'b1;
          end else if (at_limit) begin
            // Saturate instead of wrapping; a missing fall saturates high too.
            period_q <= CNT_MAX;
            ovf_q    <= 1'b1;
            done_q   <= 1'b1;
            if (!fall_seen_q && !fall) high_q <= CNT_MAX;
          end else begin
            counter_q <= counter_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          // DONE: counter and results frozen until the next arm.
        end
      endcase
    end
  end

  // Combinational register read mux.
  always_comb begin
    DATA_OUT = 8'h00;
    case (ADDRESS)
      ADDR_PERIOD_HI:  DATA_OUT = period_q[23:16];
      ADDR_PERIOD_MID: DATA_OUT = period_q[15:8];
      ADDR_PERIOD_LO:  DATA_OUT = period_q[7:0];
      ADDR_HIGH_HI:    DATA_OUT = high_q[23:16];
      ADDR_HIGH_MID:   DATA_OUT = high_q[15:8];
      ADDR_HIGH_LO:    DATA_OUT = high_q[7:0];
      ADDR_STATUS:     DATA_OUT = status_byte(done_q, busy, ovf_q);
      ADDR_CTRL:       DATA_OUT = DEVICE_ID;
      default:         DATA_OUT = 8'h00;
    endcase
  end

  assign CAPTURE_DONE = done_q;

endmodule
